// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the CPU data-memory path.
package cpu_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request fields captured at accept; the word index is kept separately
  // because its width depends on the storage depth.
  typedef struct packed {
    logic              we;
    logic              misaligned;
    logic [STRB_W-1:0] wstrb;
    logic [WORD_W-1:0] wdata;
  } req_s;

endpackage

// File: rtl/dmem_byte_merge.sv
// Byte-lane merge of new store data into an existing word.
module dmem_byte_merge
  import cpu_mem_pkg::*;
(
  input  logic [WORD_W-1:0] old_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  output logic [WORD_W-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < STRB_W; i++) begin
      if (wstrb_i[i]) merged_o[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: one outstanding request, LATENCY wait states, word
// read or byte-strobed write, response held until the requester takes it.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  req_s                  req_q, req_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [WORD_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [WORD_W-1:0]     old_c;
  logic [WORD_W-1:0]     merged_c;
  logic                  mem_we_c;

  // Upper address bits are intentionally dropped: accesses alias modulo depth.
  logic                  unused_addr_c;
  assign unused_addr_c = ^req_addr[31:DEPTH_LOG2+2];

  assign old_c = mem[idx_q];

  dmem_byte_merge u_merge (
    .old_i    (old_c),
    .wdata_i  (req_q.wdata),
    .wstrb_i  (req_q.wstrb),
    .merged_o (merged_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    idx_d    = idx_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          req_d.we         = req_we;
          req_d.misaligned = |req_addr[1:0];
          req_d.wstrb      = req_wstrb;
          req_d.wdata      = req_wdata;
          idx_d            = req_addr[DEPTH_LOG2+1:2];
          cnt_d            = CNT_W'(LATENCY);
          ready_d          = 1'b0;
          state_d          = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        // First RESP cycle performs the access; afterwards hold until taken.
        if (!valid_q) begin
          valid_d  = 1'b1;
          err_d    = req_q.misaligned;
          rdata_d  = (req_q.misaligned || req_q.we) ? '0 : old_c;
          mem_we_c = req_q.we && !req_q.misaligned;
        end else if (resp_ready) begin
          valid_d = 1'b0;
          rdata_d = '0;
          err_d   = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_q] <= merged_c;
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances against a
// timestamp-based transaction model, plus directed literal expectations.
module tb_dmem_responder;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [31:0] req_addr   [NI];
  logic [3:0]  req_wstrb  [NI];
  logic [31:0] req_wdata  [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wstrb(req_wstrb[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wstrb(req_wstrb[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Reference model: storage arrays plus per-instance transaction timestamps.
  logic [31:0] ref_mem [NI][1024];
  bit          known   [NI][1024];
  bit          busy    [NI];
  longint      due     [NI];
  bit          p_we    [NI];
  logic [31:0] p_addr  [NI];
  logic [3:0]  p_strb  [NI];
  logic [31:0] p_wdata [NI];
  bit          e_ready [NI];
  bit          e_valid [NI];
  bit          e_err   [NI];
  logic [31:0] e_rdata [NI];
  bit          e_rknown[NI];
  longint      edge_n = 0;

  always @(posedge clk or negedge reset) begin
    int unsigned idx;
    if (!reset) begin
      for (int k = 0; k < NI; k++) begin
        busy[k] = 0; e_ready[k] = 0; e_valid[k] = 0; e_err[k] = 0;
        e_rdata[k] = '0; e_rknown[k] = 1;
      end
    end else begin
      edge_n++;
      for (int k = 0; k < NI; k++) begin
        if (busy[k]) begin
          if (e_valid[k]) begin
            if (resp_ready[k]) begin
              e_valid[k] = 0; e_err[k] = 0; e_rdata[k] = '0; e_rknown[k] = 1;
              busy[k] = 0; e_ready[k] = 1;
            end
          end else if (edge_n == due[k]) begin
            idx = (p_addr[k] >> 2) % 1024;
            e_valid[k] = 1; e_rknown[k] = 1;
            if (p_addr[k] % 4 != 0) begin
              e_err[k] = 1; e_rdata[k] = '0;
            end else if (p_we[k]) begin
              for (int b = 0; b < 4; b++)
                if (p_strb[k][b]) ref_mem[k][idx][8*b +: 8] = p_wdata[k][8*b +: 8];
              if (p_strb[k] == 4'hF) known[k][idx] = 1;
              e_err[k] = 0; e_rdata[k] = '0;
            end else begin
              e_err[k] = 0; e_rdata[k] = ref_mem[k][idx]; e_rknown[k] = known[k][idx];
            end
          end
        end else if (e_ready[k] && req_valid[k]) begin
          busy[k] = 1; e_ready[k] = 0;
          due[k] = edge_n + 1 + lat_of(k);
          p_we[k] = req_we[k]; p_addr[k] = req_addr[k];
          p_strb[k] = req_wstrb[k]; p_wdata[k] = req_wdata[k];
        end else begin
          e_ready[k] = 1;
        end
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d.req_ready", k), 32'(req_ready[k]), 32'(e_ready[k]));
      chk($sformatf("i%0d.resp_valid", k), 32'(resp_valid[k]), 32'(e_valid[k]));
      chk($sformatf("i%0d.resp_err", k), 32'(resp_err[k]), 32'(e_err[k]));
      if (e_rknown[k]) chk($sformatf("i%0d.resp_rdata", k), resp_rdata[k], e_rdata[k]);
    end
  end

  // One request/response; returns first response beat and edges from accept to valid.
  task automatic txn(input int k, input bit we, input logic [31:0] addr,
                     input logic [3:0] strb, input logic [31:0] wdata, input int rdly,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_we[k] = we; req_addr[k] = addr; req_wstrb[k] = strb; req_wdata[k] = wdata;
    req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL i%0d.accept_timeout: req_ready 0 for 50 cycles, required 1", k);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'($urandom_range(0, 1));
    req_we[k] = 1'($urandom_range(0, 1)); req_addr[k] = $urandom;
    req_wstrb[k] = 4'($urandom); req_wdata[k] = $urandom;
    lat = 0;
    while (!resp_valid[k] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 40) begin
      checks++; errors++;
      $display("FAIL i%0d.resp_timeout: resp_valid 0 for 40 cycles, required 1", k);
    end
    rd = resp_rdata[k];
    er = resp_err[k];
    repeat (rdly) @(negedge clk);
    req_valid[k] = 1'b0;
    resp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    int unsigned pool [8] = '{0, 1, 4, 5, 8, 9, 'h200, 'h3FF};
    logic [31:0] a;

    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 0; req_we[k] = 0; req_addr[k] = '0; req_wstrb[k] = '0;
      req_wdata[k] = '0; resp_ready[k] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("ready_at_release", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    chk("ready_after_first_edge", 32'(req_ready[0]), 32'd1);

    txn(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd, er, lat);
    chk("store_full.lat", 32'(lat), 32'd3);
    chk("store_full.rdata", rd, 32'h0);
    chk("store_full.err", 32'(er), 32'd0);
    txn(0, 0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
    chk("load_full.rdata", rd, 32'hDEADBEEF);
    txn(0, 1, 32'h10, 4'h1, 32'h000000AA, 1, rd, er, lat);
    txn(0, 0, 32'h10, 4'hF, 32'h0, 0, rd, er, lat);
    chk("load_partial.rdata", rd, 32'hDEADBEAA);
    txn(0, 1, 32'h10, 4'h0, 32'h12345678, 0, rd, er, lat);
    txn(0, 0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
    chk("load_after_nostrb.rdata", rd, 32'hDEADBEAA);
    txn(0, 0, 32'h13, 4'h0, 32'h0, 0, rd, er, lat);
    chk("load_misaligned.err", 32'(er), 32'd1);
    chk("load_misaligned.rdata", rd, 32'h0);
    txn(0, 1, 32'h12, 4'hF, 32'hFFFFFFFF, 0, rd, er, lat);
    chk("store_misaligned.err", 32'(er), 32'd1);
    txn(0, 0, 32'h10, 4'h0, 32'h0, 5, rd, er, lat);
    chk("load_held.rdata", rd, 32'hDEADBEAA);
    chk("ready_after_handshake", 32'(req_ready[0]), 32'd1);

    txn(1, 1, 32'h1000, 4'hF, 32'hCAFEF00D, 0, rd, er, lat);
    chk("l0_store.lat", 32'(lat), 32'd1);
    txn(1, 0, 32'h0, 4'h0, 32'h0, 2, rd, er, lat);
    chk("l0_alias_load.rdata", rd, 32'hCAFEF00D);
    chk("l0_alias_load.lat", 32'(lat), 32'd1);

    // Reset while a store sits in the wait phase.
    txn(0, 1, 32'h20, 4'hF, 32'h11111111, 0, rd, er, lat);
    @(negedge clk);
    req_we[0] = 1; req_addr[0] = 32'h20; req_wstrb[0] = 4'hF;
    req_wdata[0] = 32'h22222222; req_valid[0] = 1;
    n = 0;
    while (!req_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("reset_mid.resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("reset_mid.req_ready", 32'(req_ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("reset_mid.ready_at_release", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    chk("reset_mid.ready_after_edge", 32'(req_ready[0]), 32'd1);
    txn(0, 0, 32'h20, 4'h0, 32'h0, 0, rd, er, lat);
    chk("reset_mid.store_dropped", rd, 32'h11111111);

    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 8; i++)
        txn(k, 1, 32'(pool[i] << 2), 4'hF, $urandom, 0, rd, er, lat);

    for (int t = 0; t < 160; t++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'(pool[$urandom_range(0, 7)] << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
          $urandom_range(0, 3), rd, er, lat);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
